// File: rtl/fpu_stim_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu_stim_seq
// Brief    : Vector-memory stimulus/response sequencer for an FPU with
//            valid/ready ports. Issues up to DEPTH operand tuples, collects
//            results into a readback buffer, then drains and flags end_sim.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_stim_seq #(
    parameter int          WIDTH        = 16,
    parameter int          NUM_OPERANDS = 3,
    parameter int          DEPTH        = 256,
    parameter int          DRAIN_CYCLES = 10,
    parameter bit          STALL_EN     = 1'b1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [AW:0]                         num_vec_i,
    input  logic                                load_we_i,
    input  logic [AW-1:0]                       load_addr_i,
    input  logic [NUM_OPERANDS*WIDTH-1:0]       load_data_i,
    output logic [NUM_OPERANDS-1:0][WIDTH-1:0]  operands_o,
    output logic                                in_valid_o,
    input  logic                                in_ready_i,
    input  logic [WIDTH-1:0]                    result_i,
    input  logic                                out_valid_i,
    output logic                                out_ready_o,
    input  logic [AW-1:0]                       res_addr_i,
    output logic [WIDTH-1:0]                    res_data_o,
    output logic [AW:0]                         issued_o,
    output logic [AW:0]                         received_o,
    output logic                                overflow_o,
    output logic                                busy_o,
    output logic                                end_sim_o
);

    localparam int             DW           = NUM_OPERANDS * WIDTH;
    localparam int             CW           = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW:0]    c_DEPTH_N    = (AW+1)'(DEPTH);
    localparam logic [AW:0]    c_ONE        = (AW+1)'(1);
    localparam logic [CW-1:0]  c_DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0]  c_DRAIN_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_lfsr;
    logic               w_lfsr_fb;
    logic [DW-1:0]      r_mem [DEPTH];
    logic [WIDTH-1:0]   r_buf [DEPTH];
    logic [AW:0]        r_n;
    logic [AW:0]        w_n_nxt;
    logic [AW:0]        r_issued;
    logic [AW:0]        w_issued_nxt;
    logic [AW:0]        r_received;
    logic [AW:0]        w_received_nxt;
    logic [AW:0]        w_num_clamped;
    logic [CW-1:0]      r_drain_cnt;
    logic [CW-1:0]      w_drain_cnt_nxt;
    logic               r_in_valid;
    logic               w_in_valid_nxt;
    logic               r_out_ready;
    logic               w_out_ready_nxt;
    logic               r_overflow;
    logic               w_overflow_nxt;
    logic               r_busy;
    logic               r_end_sim;
    logic [WIDTH-1:0]   r_res_data;
    logic               w_xfer;
    logic               w_acc;
    logic               w_rsp_phase;
    logic               w_buf_we;
    logic [DW-1:0]      w_rd_vec;

    assign w_xfer        = r_in_valid & in_ready_i;
    assign w_acc         = r_out_ready & out_valid_i;
    assign w_rsp_phase   = (r_state == S_ISSUE) || (r_state == S_WAIT);
    // Results beyond N are accepted (to keep the FPU moving) but not stored.
    assign w_buf_we      = w_acc & w_rsp_phase & (r_received != r_n) & ~rst_i;
    assign w_num_clamped = (num_vec_i > c_DEPTH_N) ? c_DEPTH_N : num_vec_i;
    assign w_rd_vec      = r_mem[r_issued[AW-1:0]];
    assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Operands come straight off the memory; forced to zero outside ISSUE
    // so the port is quiet (and defined) whenever nothing is being offered.
    generate
        for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_ops
            assign operands_o[k] = (r_state == S_ISSUE) ? w_rd_vec[k*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    // Next-state, counters and overflow tracking.
    always_comb begin
        w_state_nxt     = r_state;
        w_n_nxt         = r_n;
        w_issued_nxt    = r_issued;
        w_drain_cnt_nxt = r_drain_cnt;
        w_received_nxt  = w_buf_we ? (r_received + c_ONE) : r_received;
        w_overflow_nxt  = r_overflow | (w_acc & ~w_buf_we);
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_n_nxt         = w_num_clamped;
                    w_issued_nxt    = '0;
                    w_received_nxt  = '0;
                    w_overflow_nxt  = 1'b0;
                    w_drain_cnt_nxt = '0;
                    w_state_nxt     = (w_num_clamped != '0) ? S_ISSUE : S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (w_xfer) begin
                    w_issued_nxt = r_issued + c_ONE;
                    if (w_issued_nxt == r_n) begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_received_nxt == r_n) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = '0;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + c_DRAIN_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered handshake outputs derived from the upcoming state.
    always_comb begin
        w_in_valid_nxt  = 1'b0;
        w_out_ready_nxt = 1'b0;
        if (w_state_nxt == S_ISSUE) begin
            // A pending offer is held until taken; a new offer waits for the LFSR.
            w_in_valid_nxt = (r_in_valid & ~w_xfer) | !STALL_EN | r_lfsr[0];
        end
        if ((w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT)) begin
            // Once all N results are in, stay ready so surplus results drain.
            w_out_ready_nxt = !STALL_EN | r_lfsr[1] | (w_received_nxt == w_n_nxt);
        end else if (w_state_nxt == S_DRAIN) begin
            w_out_ready_nxt = 1'b1;
        end
    end

    // Control and status registers, LFSR and readback port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_n         <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_drain_cnt <= '0;
            r_in_valid  <= 1'b0;
            r_out_ready <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_end_sim   <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
            r_n         <= w_n_nxt;
            r_issued    <= w_issued_nxt;
            r_received  <= w_received_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_in_valid  <= w_in_valid_nxt;
            r_out_ready <= w_out_ready_nxt;
            r_overflow  <= w_overflow_nxt;
            r_busy      <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT) ||
                           (w_state_nxt == S_DRAIN);
            r_end_sim   <= (w_state_nxt == S_DONE);
            r_res_data  <= r_buf[res_addr_i];
        end
    end

    // Vector memory load port, only open while idle; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (r_state == S_IDLE) && load_we_i) begin
            r_mem[load_addr_i] <= load_data_i;
        end
    end

    // Result capture buffer, written in arrival order.
    always_ff @(posedge clk_i) begin
        if (w_buf_we) begin
            r_buf[r_received[AW-1:0]] <= result_i;
        end
    end

    assign in_valid_o  = r_in_valid;
    assign out_ready_o = r_out_ready;
    assign res_data_o  = r_res_data;
    assign issued_o    = r_issued;
    assign received_o  = r_received;
    assign overflow_o  = r_overflow;
    assign busy_o      = r_busy;
    assign end_sim_o   = r_end_sim;

endmodule
`default_nettype wire

// File: tb/tb_fpu_stim_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_stim_seq
// Brief    : Self-checking bench for fpu_stim_seq. Unit 0 runs without LFSR
//            throttling for cycle-exact checks, unit 1 with throttling and
//            random FPU back-pressure. A queue-based FPU model (latency 2,
//            result = op1 + op2) answers both units.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_stim_seq;

    localparam int W     = 16;
    localparam int NOP   = 3;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int D     = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst      [2];
    logic                  start    [2];
    logic [AW:0]           num_vec  [2];
    logic                  load_we;
    logic [AW-1:0]         load_addr;
    logic [NOP*W-1:0]      load_data;
    logic [NOP-1:0][W-1:0] ops      [2];
    logic                  in_valid [2];
    logic                  rdy0;
    logic                  rdy1;
    logic [W-1:0]          res      [2];
    logic                  ov       [2];
    logic                  out_ready[2];
    logic [AW-1:0]         res_addr [2];
    logic [W-1:0]          res_data [2];
    logic [AW:0]           issued   [2];
    logic [AW:0]           received [2];
    logic                  ovf      [2];
    logic                  busy     [2];
    logic                  end_sim  [2];

    fpu_stim_seq #(.WIDTH(W), .NUM_OPERANDS(NOP), .DEPTH(DEPTH), .DRAIN_CYCLES(D),
                   .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .num_vec_i(num_vec[0]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
        .operands_o(ops[0]), .in_valid_o(in_valid[0]), .in_ready_i(rdy0),
        .result_i(res[0]), .out_valid_i(ov[0]), .out_ready_o(out_ready[0]),
        .res_addr_i(res_addr[0]), .res_data_o(res_data[0]), .issued_o(issued[0]),
        .received_o(received[0]), .overflow_o(ovf[0]), .busy_o(busy[0]),
        .end_sim_o(end_sim[0]));

    fpu_stim_seq #(.WIDTH(W), .NUM_OPERANDS(NOP), .DEPTH(DEPTH), .DRAIN_CYCLES(D),
                   .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .num_vec_i(num_vec[1]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
        .operands_o(ops[1]), .in_valid_o(in_valid[1]), .in_ready_i(rdy1),
        .result_i(res[1]), .out_valid_i(ov[1]), .out_ready_o(out_ready[1]),
        .res_addr_i(res_addr[1]), .res_data_o(res_data[1]), .issued_o(issued[1]),
        .received_o(received[1]), .overflow_o(ovf[1]), .busy_o(busy[1]),
        .end_sim_o(end_sim[1]));

    int               n_chk = 0;
    int               n_err = 0;
    int               cyc   = 0;
    logic [NOP*W-1:0] mem_m [DEPTH];
    logic [W-1:0]     q_res [2][512];
    int               q_due [2][512];
    int               q_wr  [2];
    int               q_rd  [2];
    int               icnt  [2];
    int               last_iss [2];
    bit               pstall [2];
    bit               inj_act [2];
    int               inj_req [2];
    int               inj_done[2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] fpu_f(input logic [NOP*W-1:0] v);
        return v[2*W-1:W] + v[3*W-1:2*W];
    endfunction

    // FPU model output side plus random ready for the throttled unit.
    task automatic model_drive();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            rdy1 = 1'($urandom_range(0, 1));
            for (int u = 0; u < 2; u++) begin
                if (inj_req[u] != inj_done[u]) begin
                    inj_done[u]++;
                    inj_act[u] = 1'b1;
                    ov[u]      = 1'b1;
                    res[u]     = 16'hDEAD;
                end else begin
                    inj_act[u] = 1'b0;
                    if (q_wr[u] != q_rd[u] && q_due[u][q_rd[u] & 511] <= cyc) begin
                        ov[u]  = 1'b1;
                        res[u] = q_res[u][q_rd[u] & 511];
                    end else begin
                        ov[u]  = 1'b0;
                        res[u] = '0;
                    end
                end
            end
        end
    endtask

    // Observe handshakes mid-cycle: score operands, hold rule, FPU pipeline.
    task automatic model_sample();
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                logic rd_y;
                rd_y = (u == 0) ? rdy0 : rdy1;
                if (rst[u]) begin
                    q_rd[u]   = q_wr[u];
                    icnt[u]   = 0;
                    pstall[u] = 1'b0;
                end else begin
                    if (start[u]) icnt[u] = 0;
                    if (pstall[u])
                        chk("hold", {15'd0, in_valid[u], ops[u]}, {15'd0, 1'b1, mem_m[icnt[u] & 255]});
                    if (in_valid[u] && rd_y) begin
                        chk("opnd", {16'd0, ops[u]}, {16'd0, mem_m[icnt[u] & 255]});
                        q_res[u][q_wr[u] & 511] = ops[u][1] + ops[u][2];
                        q_due[u][q_wr[u] & 511] = cyc + 2;
                        q_wr[u]++;
                        icnt[u]++;
                        last_iss[u] = cyc;
                    end
                    pstall[u] = in_valid[u] && !rd_y;
                    if (ov[u] && out_ready[u] && !inj_act[u]) q_rd[u]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int u, input logic [AW:0] n);
        start[u]   = 1'b1;
        num_vec[u] = n;
        step();
        start[u]   = 1'b0;
    endtask

    task automatic pulse_rst(input int u);
        rst[u] = 1'b1;
        step();
        rst[u] = 1'b0;
    endtask

    task automatic wait_end(input int u, input int budget);
        int k = 0;
        while (!end_sim[u] && k < budget) begin
            step();
            k++;
        end
        if (!end_sim[u]) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic rb(input int u, input int i, input logic [W-1:0] e);
        res_addr[u] = AW'(i);
        step();
        chk("buf", {48'd0, res_data[u]}, {48'd0, e});
    endtask

    initial begin
        int nv;
        int k;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; num_vec[u] = '0; ov[u] = 1'b0; res[u] = '0;
            res_addr[u] = '0; q_wr[u] = 0; q_rd[u] = 0; icnt[u] = 0; last_iss[u] = 0;
            pstall[u] = 1'b0; inj_act[u] = 1'b0; inj_req[u] = 0; inj_done[u] = 0;
        end
        load_we = 1'b0; load_addr = '0; load_data = '0; rdy0 = 1'b1; rdy1 = 1'b0;
        fork
            model_drive();
            model_sample();
        join_none
        repeat (3) step();

        // Reset values
        chk("rst_valid", in_valid[0], 0);  chk("rst_ordy", out_ready[0], 0);
        chk("rst_iss", issued[0], 0);      chk("rst_rcv", received[0], 0);
        chk("rst_ovf", ovf[0], 0);         chk("rst_busy", busy[0], 0);
        chk("rst_end", end_sim[0], 0);     chk("rst_rdata", res_data[0], 0);
        chk("rst_ops", ops[0], 0);         chk("rst_ordy1", out_ready[1], 0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();

        // Fill both memories with random tuples
        for (int i = 0; i < DEPTH; i++) begin
            load_we   = 1'b1;
            load_addr = AW'(i);
            load_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            mem_m[i]  = load_data;
            step();
        end
        load_we = 1'b0;

        // Full-depth runs: unit 1 throttled at N=256, unit 0 with 300 clamped to 256
        start[0] = 1'b1; num_vec[0] = 9'd300;
        start[1] = 1'b1; num_vec[1] = 9'd256;
        step();
        start[0] = 1'b0; start[1] = 1'b0;
        wait_end(0, 3000);
        wait_end(1, 20000);
        chk("clamp_iss", issued[0], 256);  chk("clamp_rcv", received[0], 256);
        chk("st_iss", issued[1], 256);     chk("st_rcv", received[1], 256);
        chk("st_ovf", ovf[1], 0);
        for (int i = 0; i < DEPTH; i++) rb(1, i, fpu_f(mem_m[i]));
        for (int i = 0; i < DEPTH; i += 37) rb(0, i, fpu_f(mem_m[i]));

        // Directed FP16 tuples, N=4, one vector per cycle, drain timing
        pulse_rst(0);
        for (int i = 0; i < 4; i++) begin
            load_we   = 1'b1;
            load_addr = AW'(i);
            load_data = {16'(i * 3), 16'h4000 + 16'(i * 256), 16'h3C00};
            mem_m[i]  = load_data;
            step();
        end
        load_we = 1'b0;
        pulse_start(0, 9'd4);
        chk("t1_valid", in_valid[0], 1);   chk("t1_busy", busy[0], 1);
        repeat (4) step();
        chk("t1_iss4", issued[0], 4);      chk("t1_vdrop", in_valid[0], 0);
        wait_end(0, 100);
        chk("t1_endlat", cyc - last_iss[0], 2 + D + 1);
        chk("t1_rcv", received[0], 4);     chk("t1_ovf", ovf[0], 0);
        rb(0, 0, 16'h4000);
        for (int i = 1; i < 4; i++) rb(0, i, fpu_f(mem_m[i]));

        // Back-pressure hold, then an extra result after the last one
        pulse_rst(0);
        rdy0 = 1'b0;
        pulse_start(0, 9'd4);
        for (int i = 0; i < 5; i++) begin
            chk("st_vld", in_valid[0], 1);
            chk("st_iss", issued[0], 0);
            chk("st_ops", ops[0], mem_m[0]);
            step();
        end
        rdy0 = 1'b1;
        step();
        chk("st_first", issued[0], 1);
        k = 0;
        while (received[0] != 4 && k < 100) begin step(); k++; end
        chk("st_rcv4", received[0], 4);
        inj_req[0]++;
        wait_end(0, 100);
        chk("ovf_set", ovf[0], 1);         chk("ovf_rcv", received[0], 4);
        for (int i = 0; i < 4; i++) rb(0, i, fpu_f(mem_m[i]));

        // N=0 goes straight through DRAIN; start in DONE is ignored
        pulse_rst(0);
        pulse_start(0, 9'd0);
        chk("z_busy", busy[0], 1);
        nv = 0;
        for (int i = 1; i < D; i++) begin
            nv += int'(in_valid[0]);
            step();
        end
        chk("z_early", end_sim[0], 0);
        nv += int'(in_valid[0]);
        step();
        chk("z_end", end_sim[0], 1);
        chk("z_novalid", nv, 0);
        pulse_start(0, 9'd4);
        chk("done_busy", busy[0], 0);      chk("done_end", end_sim[0], 1);
        chk("done_vld", in_valid[0], 0);

        // Reset mid-run at issued=3, then re-run from retained memory
        pulse_rst(0);
        pulse_start(0, 9'd8);
        k = 0;
        while (issued[0] != 3 && k < 50) begin step(); k++; end
        chk("mr_at3", issued[0], 3);
        rst[0] = 1'b1;
        step();
        chk("mr_vld", in_valid[0], 0);     chk("mr_iss", issued[0], 0);
        chk("mr_rcv", received[0], 0);     chk("mr_busy", busy[0], 0);
        chk("mr_ordy", out_ready[0], 0);   chk("mr_ops", ops[0], 0);
        rst[0] = 1'b0;
        step();
        pulse_start(0, 9'd4);
        wait_end(0, 100);
        chk("mr_iss4", issued[0], 4);      chk("mr_ovf", ovf[0], 0);
        for (int i = 0; i < 4; i++) rb(0, i, fpu_f(mem_m[i]));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_stim_seq.md
# fpu_stim_seq

Parametrised stimulus/response sequencer for FPU unit benches and on-board self-test. It replaces the fixed 16-bit free-running operand generator with a vector memory of DEPTH operand tuples, NUM_OPERANDS wide. Vectors are issued to an fpnew_top-style valid/ready input port, and results are collected from the output port into a readback buffer. An optional LFSR throttles both handshakes. The block sits between the clock generator and the FPU; it raises end_sim_o after the last result is collected and a drain period has elapsed.

## Interface
- WIDTH, 16, operand/result width in bits (16, 32, 64)
- NUM_OPERANDS, 3, operands per vector
- DEPTH, 256, vector memory and result buffer entries (power of two, ≥2)
- DRAIN_CYCLES, 10, idle cycles between last result and end_sim_o (≥1)
- STALL_EN, 1, enables LFSR throttling of in_valid_o and out_ready_o
- LFSR_SEED, 16'hACE1, nonzero reset seed of 16-bit Fibonacci LFSR (taps 16,14,13,11)

Ports (AW = $clog2(DEPTH)):
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a run (sampled in IDLE only)
- num_vec_i  in  AW+1  vectors to issue, sampled with start_i; values >DEPTH are clamped to DEPTH
- load_we_i  in  1  vector memory write strobe (IDLE only)
- load_addr_i  in  AW  vector memory write address
- load_data_i  in  NUM_OPERANDS*WIDTH  packed tuple; operand k is at bits [k*WIDTH +: WIDTH]
- operands_o  out  [NUM_OPERANDS-1:0][WIDTH-1:0]  operands to FPU
- in_valid_o  out  1  operands valid
- in_ready_i  in  1  FPU accepts operands
- result_i  in  WIDTH  FPU result
- out_valid_i  in  1  result valid
- out_ready_o  out  1  sequencer accepts result
- res_addr_i  in  AW  result buffer read address
- res_data_o  out  WIDTH  result buffer read data
- issued_o  out  AW+1  accepted input transfers this run
- received_o  out  AW+1  accepted results this run
- overflow_o  out  1  sticky: result arrived after received_o==num_vec
- busy_o  out  1  state ≠ IDLE and ≠ DONE
- end_sim_o  out  1  run complete

## Operation
- FSM states: IDLE → ISSUE → WAIT → DRAIN → DONE.
- IDLE:
  - load_we_i writes the vector memory; writes in any other state are ignored.
  - start_i latches N = min(num_vec_i, DEPTH) and clears the counters and overflow_o.
  - Next state is ISSUE if N>0, otherwise DRAIN.
- ISSUE:
  - operands_o = mem[issue_ptr].
  - Transfer occurs when in_valid_o && in_ready_i; on each transfer, issue_ptr and issued_o increment.
  - Once in_valid_o is high it stays high, with operands_o stable, until the transfer completes.
  - When in_valid_o is low and STALL_EN=1, in_valid_o rises only when lfsr[0]=1. When STALL_EN=0, it rises immediately.
  - On the transfer of vector N-1, in_valid_o drops and the state goes to WAIT.
- Results (ISSUE and WAIT):
  - out_ready_o = 1 when STALL_EN=0, otherwise lfsr[1]. It may fall at any cycle.
  - Each out_valid_i && out_ready_o writes result_i to buf[received_o], then received_o increments.
  - When received_o==N, a further accepted result sets overflow_o and is discarded. out_ready_o stays asserted in that case.
- WAIT → DRAIN when received_o==N, including the case where this holds already at ISSUE exit. A result accepted on the same cycle as the last issue is counted.
- DRAIN: counts DRAIN_CYCLES cycles with out_ready_o=1; results arriving here set overflow_o. Then the state goes to DONE.
- DONE: end_sim_o=1 and is held; start_i is ignored. Only rst_i leaves DONE.
- The LFSR advances every cycle outside reset.
- Readback: res_data_o = buf[res_addr_i], registered, usable in any state.

## Timing
- Reset values:
  - state=IDLE; in_valid_o=0; out_ready_o=0.
  - issued_o=0; received_o=0; overflow_o=0; busy_o=0; end_sim_o=0.
  - operands_o=0; res_data_o=0; lfsr=LFSR_SEED.
  - Memory contents are not reset.
- start_i at cycle t gives ISSUE at t+1; in_valid_o is first high at t+1 (STALL_EN=0).
- STALL_EN=0 with in_ready_i tied high issues one vector per cycle; N vectors take N cycles.
- Load write at t is visible to issue from t+1. Readback latency is 1 cycle.
- With the last result accepted at t, end_sim_o rises at t+1+DRAIN_CYCLES.
- rst_i mid-run aborts immediately: in_valid_o=0 the following cycle, and the memory keeps its contents.
- All outputs are registered except operands_o, which is a memory read off issue_ptr.

## Test plan
- STALL_EN=0, load 4 FP16 tuples (3C00,4000,·)…, N=4, FPU pipe latency 2 → issued_o=4 in 4 cycles; buf[0]=4000; end_sim_o rises 2+DRAIN_CYCLES+1 cycles after the last issue.
- in_ready_i low for 5 cycles while in_valid_o=1 → operands_o unchanged and issued_o frozen; transfer on the first ready cycle.
- STALL_EN=1, N=DEPTH=256, random in_ready_i → issued_o=received_o=256, buf matches golden model, overflow_o=0.
- Inject an extra out_valid_i pulse after the final result → overflow_o=1, buf unchanged, end_sim_o still asserts.
- start_i with num_vec_i=0 → DRAIN then DONE, no in_valid_o pulse; num_vec_i=300 with DEPTH=256 → N=256.
- rst_i asserted at issued_o=3 → all outputs return to reset values next cycle; re-start reissues from vector 0 using the retained memory.
